// File: rtl/dual_issue_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : dual_issue_ctrl_pkg
// Description : Shared definitions for the dual-issue scheduler: scheduler
//               state encoding and the default register-address width.
// Revision    : 1.0 - initial release
// ============================================================================
package dual_issue_ctrl_pkg;

  // Default architectural register-address width (32 GPRs).
  localparam int RA_W_DEF = 5;

  // PAIR : slot0 not yet issued, the whole IF/ID pair is a candidate.
  // SPLIT: slot0 already went down lane 0, slot1 still pending.
  typedef enum logic {
    ST_PAIR  = 1'b0,
    ST_SPLIT = 1'b1
  } state_e;

endpackage
`default_nettype wire

// File: rtl/dual_issue_ctrl_hazard_check.sv
`default_nettype none
// ============================================================================
// Module      : hazard_check
// Description : Load-use hazard detect for one decoded instruction against
//               the two in-EX load trackers (one per lane).
//   use_rs1/use_rs2 : source is actually read
//   rs1/rs2         : source register addresses
//   ld0_v/ld0_rd    : lane-0 load tracker (load now in EX)
//   ld1_v/ld1_rd    : lane-1 load tracker
//   luh             : 1 = instruction must wait for a load result
// Revision    : 1.0 - initial release
// ============================================================================
module hazard_check
  import dual_issue_ctrl_pkg::*;
#(
  parameter int RA_W = RA_W_DEF
) (
  input  logic            use_rs1,
  input  logic            use_rs2,
  input  logic [RA_W-1:0] rs1,
  input  logic [RA_W-1:0] rs2,
  input  logic            ld0_v,
  input  logic [RA_W-1:0] ld0_rd,
  input  logic            ld1_v,
  input  logic [RA_W-1:0] ld1_rd,
  output logic            luh
);

  logic w_hit0;
  logic w_hit1;

  // x0 is hardwired to zero, so a load targeting it never creates a hazard.
  always_comb begin
    w_hit0 = ld0_v && (ld0_rd != '0) &&
             ((use_rs1 && (rs1 == ld0_rd)) || (use_rs2 && (rs2 == ld0_rd)));
    w_hit1 = ld1_v && (ld1_rd != '0) &&
             ((use_rs1 && (rs1 == ld1_rd)) || (use_rs2 && (rs2 == ld1_rd)));
    luh    = w_hit0 || w_hit1;
  end

endmodule
`default_nettype wire

// File: rtl/dual_issue_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : dual_issue_ctrl
// Description : Issue scheduler for the two-issue pipeline. Decides each
//               cycle whether 0, 1 or 2 instructions of the IF/ID pair enter
//               EX, steering the per-lane ID/EX bubble inputs and holding
//               fetch while a pair is only partly issued.
//   clk, rst            : clock, synchronous active-high reset
//   flush               : EX redirect; kills the pair and any pending split
//   s0_* / s1_*         : decoded IF/ID slot info (slot0 = older)
//   lane0/1_stall       : 1 = bubble that lane's ID/EX register
//   lane0_sel           : 1 = lane 0 takes slot1 (second half of a split)
//   fetch_hold          : 1 = IF/ID pair must not advance
//   split               : registered, slot0 issued and slot1 pending
//   stall_cnt           : saturating count of lane-0 bubble cycles with work
// Revision    : 1.0 - initial release
// ============================================================================
module dual_issue_ctrl
  import dual_issue_ctrl_pkg::*;
#(
  parameter int RA_W  = RA_W_DEF,
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             s0_valid,
  input  logic             s1_valid,
  input  logic [RA_W-1:0]  s0_rd,
  input  logic [RA_W-1:0]  s1_rd,
  input  logic [RA_W-1:0]  s0_rs1,
  input  logic [RA_W-1:0]  s0_rs2,
  input  logic [RA_W-1:0]  s1_rs1,
  input  logic [RA_W-1:0]  s1_rs2,
  input  logic             s0_use_rs1,
  input  logic             s0_use_rs2,
  input  logic             s1_use_rs1,
  input  logic             s1_use_rs2,
  input  logic             s0_wr,
  input  logic             s1_wr,
  input  logic             s0_load,
  input  logic             s1_load,
  input  logic             s0_mem,
  input  logic             s1_mem,
  input  logic             s0_ctrl,
  input  logic             s1_ctrl,
  output logic             lane0_stall,
  output logic             lane1_stall,
  output logic             lane0_sel,
  output logic             fetch_hold,
  output logic             split,
  output logic [CNT_W-1:0] stall_cnt
);

  state_e            state_q, state_d;
  logic              ld0_v_q, ld0_v_d;
  logic              ld1_v_q, ld1_v_d;
  logic [RA_W-1:0]   ld0_rd_q, ld0_rd_d;
  logic [RA_W-1:0]   ld1_rd_q, ld1_rd_d;
  logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;

  logic w_luh0;
  logic w_luh1;
  logic w_raw;
  logic w_waw;
  logic w_mem2;
  logic w_pair_ok;

  // slot1 branch/jump status does not affect pairing; a younger control
  // instruction may share a pair with an older one.
  logic unused_s1_ctrl;
  assign unused_s1_ctrl = s1_ctrl;

  hazard_check #(.RA_W(RA_W)) u_hz_s0 (
    .use_rs1 (s0_use_rs1),
    .use_rs2 (s0_use_rs2),
    .rs1     (s0_rs1),
    .rs2     (s0_rs2),
    .ld0_v   (ld0_v_q),
    .ld0_rd  (ld0_rd_q),
    .ld1_v   (ld1_v_q),
    .ld1_rd  (ld1_rd_q),
    .luh     (w_luh0)
  );

  hazard_check #(.RA_W(RA_W)) u_hz_s1 (
    .use_rs1 (s1_use_rs1),
    .use_rs2 (s1_use_rs2),
    .rs1     (s1_rs1),
    .rs2     (s1_rs2),
    .ld0_v   (ld0_v_q),
    .ld0_rd  (ld0_rd_q),
    .ld1_v   (ld1_v_q),
    .ld1_rd  (ld1_rd_q),
    .luh     (w_luh1)
  );

  assign split     = (state_q == ST_SPLIT);
  assign stall_cnt = stall_cnt_q;

  // Intra-pair hazards that forbid slot1 from issuing alongside slot0.
  always_comb begin
    w_raw  = s0_wr && (s0_rd != '0) &&
             ((s1_use_rs1 && (s1_rs1 == s0_rd)) ||
              (s1_use_rs2 && (s1_rs2 == s0_rd)));
    w_waw  = s0_wr && s1_wr && (s0_rd == s1_rd) && (s0_rd != '0);
    w_mem2 = s0_mem && s1_mem;
    // Slot1 waits behind a control instruction so a redirect can kill it.
    w_pair_ok = s1_valid && !w_luh1 && !w_raw && !w_waw && !w_mem2 && !s0_ctrl;
  end

  always_comb begin
    state_d     = state_q;
    lane0_stall = 1'b1;
    lane1_stall = 1'b1;
    lane0_sel   = (state_q == ST_SPLIT);
    fetch_hold  = 1'b0;

    case (state_q)
      ST_PAIR: begin
        if (flush || !s0_valid) begin
          // nothing issues, pair may advance
        end else if (w_luh0) begin
          fetch_hold = 1'b1;
        end else begin
          lane0_stall = 1'b0;
          if (s1_valid) begin
            if (w_pair_ok) begin
              lane1_stall = 1'b0;
            end else begin
              fetch_hold = 1'b1;
              state_d    = ST_SPLIT;
            end
          end
        end
      end
      ST_SPLIT: begin
        if (flush) begin
          state_d = ST_PAIR;
        end else if (w_luh1) begin
          fetch_hold = 1'b1;
        end else begin
          lane0_stall = 1'b0;
          state_d     = ST_PAIR;
        end
      end
      default: state_d = ST_PAIR;
    endcase

    if (rst) begin
      state_d     = ST_PAIR;
      lane0_stall = 1'b1;
      lane1_stall = 1'b1;
      lane0_sel   = 1'b0;
      fetch_hold  = 1'b0;
    end

    // Trackers describe exactly what enters EX this cycle; a bubbled lane
    // carries no load.
    ld0_v_d  = !lane0_stall && (lane0_sel ? s1_load : s0_load);
    ld0_rd_d = ld0_v_d ? (lane0_sel ? s1_rd : s0_rd) : '0;
    ld1_v_d  = !lane1_stall && s1_load;
    ld1_rd_d = ld1_v_d ? s1_rd : '0;

    stall_cnt_d = stall_cnt_q;
    if (lane0_stall && (s0_valid || (state_q == ST_SPLIT)) &&
        (stall_cnt_q != {CNT_W{1'b1}})) begin
      stall_cnt_d = stall_cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_PAIR;
      ld0_v_q     <= 1'b0;
      ld1_v_q     <= 1'b0;
      ld0_rd_q    <= '0;
      ld1_rd_q    <= '0;
      stall_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      ld0_v_q     <= ld0_v_d;
      ld1_v_q     <= ld1_v_d;
      ld0_rd_q    <= ld0_rd_d;
      ld1_rd_q    <= ld1_rd_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

endmodule
`default_nettype wire
